// File: rtl/cp0_exc_ctrl.sv
// Exception/ERET commit sequencer: latches the committing cause, writes cp0, flushes, then redirects fetch.
// Optional event counters (exc_count/eret_count) are enabled by defining CP0_EXC_CTRL_STAT_EN.
module cp0_exc_ctrl #(
    parameter logic [31:0] EXC_BASE     = 32'hBFC00200,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        commit_valid,
    input  logic [31:0] commit_pc,
    input  logic        commit_bd,
    input  logic [9:0]  commit_exc,
    input  logic        commit_tlb_refill,
    input  logic [31:0] commit_daddr,
    input  logic        commit_eret,
    input  logic        cp0_has_int,
    input  logic        cp0_status_exl,
    input  logic        cp0_cause_bd,
    input  logic [31:0] cp0_epc,
    input  logic        mem_busy,
    output logic        busy,
    output logic        flush,
    output logic        redirect_ena,
    output logic [31:0] redirect_pc,
    output logic        w_cp0_update_ena,
    output logic [4:0]  w_cp0_exccode,
    output logic        w_cp0_bd,
    output logic        w_cp0_exl,
    output logic [31:0] w_cp0_epc,
    output logic        w_cp0_badvaddr_ena,
    output logic [31:0] w_cp0_badvaddr,
`ifdef CP0_EXC_CTRL_STAT_EN
    output logic [31:0] exc_count,
    output logic [31:0] eret_count,
`endif
    output logic        cp0_cls_exl
);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_COMMIT, S_FLUSH, S_REDIRECT} state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        l_eret_q, l_bva_ena_q, l_bd_q;
    logic [4:0]  l_code_q;
    logic [31:0] l_bva_q, l_epc_q, l_tgt_q;
    logic        busy_q, flush_q, redir_ena_q, upd_q, bd_q, exl_q, bva_ena_q, cls_q;
    logic [31:0] redir_pc_q, epc_q, bva_q;
    logic [4:0]  code_q;

    logic        exc_take, accept, go_commit, tlb_d, bva_ena_d, bd_d;
    logic [4:0]  code_d;
    logic [31:0] bva_d, epc_d, tgt_d;
    logic        src_eret, src_bva_ena, src_bd;
    logic [4:0]  src_code;
    logic [31:0] src_bva, src_epc;

    // Priority encoder over the cause flags; interrupt wins over everything.
    always_comb begin
        code_d    = 5'd0;
        bva_ena_d = 1'b0;
        bva_d     = 32'd0;
        tlb_d     = 1'b0;
        if (cp0_has_int)        code_d = 5'd0;
        else if (commit_exc[0]) begin code_d = 5'd4;  bva_ena_d = 1'b1; bva_d = commit_pc; end
        else if (commit_exc[1]) begin code_d = 5'd2;  bva_ena_d = 1'b1; bva_d = commit_pc; tlb_d = 1'b1; end
        else if (commit_exc[2]) code_d = 5'd10;
        else if (commit_exc[3]) code_d = 5'd12;
        else if (commit_exc[4]) code_d = 5'd8;
        else if (commit_exc[5]) code_d = 5'd9;
        else if (commit_exc[6]) begin code_d = 5'd4;  bva_ena_d = 1'b1; bva_d = commit_daddr; end
        else if (commit_exc[7]) begin code_d = 5'd5;  bva_ena_d = 1'b1; bva_d = commit_daddr; end
        else if (commit_exc[8]) begin code_d = 5'd2;  bva_ena_d = 1'b1; bva_d = commit_daddr; tlb_d = 1'b1; end
        else if (commit_exc[9]) begin code_d = 5'd3;  bva_ena_d = 1'b1; bva_d = commit_daddr; tlb_d = 1'b1; end
    end

    assign exc_take = cp0_has_int | (|commit_exc);
    assign accept   = (state_q == S_IDLE) & commit_valid & (exc_take | commit_eret);
    assign epc_d    = cp0_status_exl ? cp0_epc : (commit_bd ? commit_pc - 32'd4 : commit_pc);
    assign bd_d     = cp0_status_exl ? cp0_cause_bd : commit_bd;
    assign tgt_d    = !exc_take ? cp0_epc :
                      (tlb_d & commit_tlb_refill & !cp0_status_exl) ? EXC_BASE : EXC_BASE + 32'h180;

    assign go_commit = !mem_busy & (accept | (state_q == S_WAIT));

    // A direct IDLE->COMMIT hop has not latched yet, so it reads the decoded values.
    always_comb begin
        src_eret    = l_eret_q;
        src_code    = l_code_q;
        src_bva_ena = l_bva_ena_q;
        src_bva     = l_bva_q;
        src_epc     = l_epc_q;
        src_bd      = l_bd_q;
        if (state_q == S_IDLE) begin
            src_eret    = !exc_take;
            src_code    = code_d;
            src_bva_ena = bva_ena_d;
            src_bva     = bva_d;
            src_epc     = epc_d;
            src_bd      = bd_d;
        end
    end

`ifdef CP0_EXC_CTRL_STAT_EN
    logic [31:0] exc_cnt_q, eret_cnt_q;
    assign exc_count  = exc_cnt_q;
    assign eret_count = eret_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            exc_cnt_q  <= 32'd0;
            eret_cnt_q <= 32'd0;
        end else if (state_q == S_COMMIT) begin
            if (l_eret_q) eret_cnt_q <= eret_cnt_q + 32'd1;
            else          exc_cnt_q  <= exc_cnt_q + 32'd1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            l_eret_q    <= 1'b0;
            l_code_q    <= 5'd0;
            l_bva_ena_q <= 1'b0;
            l_bva_q     <= 32'd0;
            l_epc_q     <= 32'd0;
            l_bd_q      <= 1'b0;
            l_tgt_q     <= 32'd0;
            busy_q      <= 1'b0;
            flush_q     <= 1'b0;
            redir_ena_q <= 1'b0;
            redir_pc_q  <= 32'd0;
            upd_q       <= 1'b0;
            code_q      <= 5'd0;
            bd_q        <= 1'b0;
            exl_q       <= 1'b0;
            epc_q       <= 32'd0;
            bva_ena_q   <= 1'b0;
            bva_q       <= 32'd0;
            cls_q       <= 1'b0;
        end else begin
            // Outputs describe the next state; everything defaults low.
            busy_q      <= 1'b0;
            flush_q     <= 1'b0;
            redir_ena_q <= 1'b0;
            redir_pc_q  <= 32'd0;
            upd_q       <= 1'b0;
            code_q      <= 5'd0;
            bd_q        <= 1'b0;
            exl_q       <= 1'b0;
            epc_q       <= 32'd0;
            bva_ena_q   <= 1'b0;
            bva_q       <= 32'd0;
            cls_q       <= 1'b0;
            case (state_q)
                S_IDLE: if (accept) begin
                    l_eret_q    <= !exc_take;
                    l_code_q    <= code_d;
                    l_bva_ena_q <= bva_ena_d;
                    l_bva_q     <= bva_d;
                    l_epc_q     <= epc_d;
                    l_bd_q      <= bd_d;
                    l_tgt_q     <= tgt_d;
                    busy_q      <= 1'b1;
                    state_q     <= mem_busy ? S_WAIT : S_COMMIT;
                end
                S_WAIT: begin
                    busy_q <= 1'b1;
                    if (!mem_busy) state_q <= S_COMMIT;
                end
                S_COMMIT: begin
                    busy_q  <= 1'b1;
                    flush_q <= 1'b1;
                    cnt_q   <= 4'(FLUSH_CYCLES);
                    state_q <= S_FLUSH;
                end
                S_FLUSH: begin
                    busy_q  <= 1'b1;
                    flush_q <= 1'b1;
                    if (cnt_q <= 4'd1) begin
                        state_q     <= S_REDIRECT;
                        redir_ena_q <= 1'b1;
                        redir_pc_q  <= l_tgt_q;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_REDIRECT: state_q <= S_IDLE;
                default:    state_q <= S_IDLE;
            endcase
            if (go_commit) begin
                flush_q <= 1'b1;
                if (src_eret) begin
                    cls_q <= 1'b1;
                end else begin
                    upd_q     <= 1'b1;
                    exl_q     <= 1'b1;
                    code_q    <= src_code;
                    bd_q      <= src_bd;
                    epc_q     <= src_epc;
                    bva_ena_q <= src_bva_ena;
                    bva_q     <= src_bva;
                end
            end
        end
    end

    assign busy               = busy_q;
    assign flush              = flush_q;
    assign redirect_ena       = redir_ena_q;
    assign redirect_pc        = redir_pc_q;
    assign w_cp0_update_ena   = upd_q;
    assign w_cp0_exccode      = code_q;
    assign w_cp0_bd           = bd_q;
    assign w_cp0_exl          = exl_q;
    assign w_cp0_epc          = epc_q;
    assign w_cp0_badvaddr_ena = bva_ena_q;
    assign w_cp0_badvaddr     = bva_q;
    assign cp0_cls_exl        = cls_q;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl (default parameters, FLUSH_CYCLES=2); outputs sampled on the falling edge.
module tb_cp0_exc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        commit_valid, commit_bd, commit_tlb_refill, commit_eret;
    logic [31:0] commit_pc, commit_daddr, cp0_epc;
    logic [9:0]  commit_exc;
    logic        cp0_has_int, cp0_status_exl, cp0_cause_bd, mem_busy;
    logic        busy, flush, redirect_ena, w_cp0_update_ena, w_cp0_bd, w_cp0_exl;
    logic        w_cp0_badvaddr_ena, cp0_cls_exl;
    logic [31:0] redirect_pc, w_cp0_epc, w_cp0_badvaddr;
    logic [4:0]  w_cp0_exccode;

    int checks = 0;
    int errors = 0;

    cp0_exc_ctrl dut (
        .clk(clk), .rst(rst),
        .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_bd(commit_bd),
        .commit_exc(commit_exc), .commit_tlb_refill(commit_tlb_refill),
        .commit_daddr(commit_daddr), .commit_eret(commit_eret),
        .cp0_has_int(cp0_has_int), .cp0_status_exl(cp0_status_exl),
        .cp0_cause_bd(cp0_cause_bd), .cp0_epc(cp0_epc), .mem_busy(mem_busy),
        .busy(busy), .flush(flush), .redirect_ena(redirect_ena), .redirect_pc(redirect_pc),
        .w_cp0_update_ena(w_cp0_update_ena), .w_cp0_exccode(w_cp0_exccode),
        .w_cp0_bd(w_cp0_bd), .w_cp0_exl(w_cp0_exl), .w_cp0_epc(w_cp0_epc),
        .w_cp0_badvaddr_ena(w_cp0_badvaddr_ena), .w_cp0_badvaddr(w_cp0_badvaddr),
        .cp0_cls_exl(cp0_cls_exl)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic req(input logic [31:0] pc, input logic bd, input logic [9:0] exc,
                       input logic refill, input logic [31:0] daddr, input logic eret,
                       input logic intr, input logic exl, input logic cbd, input logic [31:0] epc);
        commit_valid = 1'b1; commit_pc = pc; commit_bd = bd; commit_exc = exc;
        commit_tlb_refill = refill; commit_daddr = daddr; commit_eret = eret;
        cp0_has_int = intr; cp0_status_exl = exl; cp0_cause_bd = cbd; cp0_epc = epc;
    endtask

    task automatic drop();
        commit_valid = 1'b0; commit_exc = 10'd0; commit_eret = 1'b0; cp0_has_int = 1'b0;
    endtask

    // From COMMIT: two FLUSH cycles, one REDIRECT, then back to IDLE.
    task automatic tail(input string tag, input logic [31:0] tgt);
        step();
        chk({tag, ".f1.flush"}, 32'(flush), 32'd1);
        chk({tag, ".f1.upd"}, 32'(w_cp0_update_ena | cp0_cls_exl | redirect_ena), 32'd0);
        step();
        chk({tag, ".f2.flush"}, 32'(flush), 32'd1);
        chk({tag, ".f2.redir"}, 32'(redirect_ena), 32'd0);
        step();
        chk({tag, ".rd.ena"}, 32'(redirect_ena), 32'd1);
        chk({tag, ".rd.pc"}, redirect_pc, tgt);
        chk({tag, ".rd.flush"}, 32'(flush & busy), 32'd1);
        step();
        chk({tag, ".idle"}, 32'({busy, flush, redirect_ena}), 32'd0);
    endtask

    initial begin
        rst = 1'b1; mem_busy = 1'b0; commit_pc = '0; commit_bd = 1'b0; commit_daddr = '0;
        commit_tlb_refill = 1'b0; cp0_status_exl = 1'b0; cp0_cause_bd = 1'b0; cp0_epc = '0;
        drop();
        step(); step();
        chk("rst.ctl", 32'({busy, flush, redirect_ena, w_cp0_update_ena, w_cp0_badvaddr_ena, cp0_cls_exl, w_cp0_exl, w_cp0_bd}), 32'd0);
        chk("rst.rpc", redirect_pc, 32'd0);
        chk("rst.epc", w_cp0_epc, 32'd0);
        chk("rst.bva", w_cp0_badvaddr, 32'd0);
        chk("rst.code", 32'(w_cp0_exccode), 32'd0);
        rst = 1'b0;

        // valid with no cause is not accepted
        commit_valid = 1'b1; step(); drop();
        chk("noacc.busy", 32'(busy), 32'd0);

        // Sys
        req(32'h80001000, 1'b0, 10'h010, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step(); drop();
        chk("sys.upd", 32'(w_cp0_update_ena), 32'd1);
        chk("sys.code", 32'(w_cp0_exccode), 32'd8);
        chk("sys.epc", w_cp0_epc, 32'h80001000);
        chk("sys.bvae", 32'(w_cp0_badvaddr_ena), 32'd0);
        chk("sys.exl", 32'(w_cp0_exl & flush & busy), 32'd1);
        chk("sys.cls", 32'(cp0_cls_exl), 32'd0);
        tail("sys", 32'hBFC00380);

        // TLBS refill, EXL=0 -> refill vector
        req(32'h80000200, 1'b0, 10'h200, 1'b1, 32'h00400004, 1'b0, 1'b0, 1'b0, 1'b0, 32'h80000ABC);
        step(); drop();
        chk("tlbs.code", 32'(w_cp0_exccode), 32'd3);
        chk("tlbs.bvae", 32'(w_cp0_badvaddr_ena), 32'd1);
        chk("tlbs.bva", w_cp0_badvaddr, 32'h00400004);
        chk("tlbs.epc", w_cp0_epc, 32'h80000200);
        tail("tlbs", 32'hBFC00200);

        // TLBS refill, EXL=1 -> general vector, EPC/BD preserved
        req(32'h80000200, 1'b0, 10'h200, 1'b1, 32'h00400004, 1'b0, 1'b0, 1'b1, 1'b1, 32'h80000ABC);
        step(); drop();
        chk("tlbs1.code", 32'(w_cp0_exccode), 32'd3);
        chk("tlbs1.epc", w_cp0_epc, 32'h80000ABC);
        chk("tlbs1.bd", 32'(w_cp0_bd), 32'd1);
        cp0_status_exl = 1'b0; cp0_cause_bd = 1'b0;
        tail("tlbs1", 32'hBFC00380);

        // interrupt outranks RI in a delay slot
        req(32'h80000104, 1'b1, 10'h004, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        step(); drop();
        chk("int.code", 32'(w_cp0_exccode), 32'd0);
        chk("int.epc", w_cp0_epc, 32'h80000100);
        chk("int.bd", 32'(w_cp0_bd), 32'd1);
        tail("int", 32'hBFC00380);

        // ERET alone
        req(32'h80000300, 1'b0, 10'h000, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h80002000);
        step(); drop(); cp0_epc = 32'h0; cp0_status_exl = 1'b0;
        chk("eret.cls", 32'(cp0_cls_exl), 32'd1);
        chk("eret.upd", 32'(w_cp0_update_ena), 32'd0);
        chk("eret.flush", 32'(flush), 32'd1);
        tail("eret", 32'h80002000);

        // ERET with Ov -> exception wins
        req(32'h80000300, 1'b0, 10'h008, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h80002000);
        step(); drop();
        chk("eov.code", 32'(w_cp0_exccode), 32'd12);
        chk("eov.cls", 32'(cp0_cls_exl), 32'd0);
        chk("eov.upd", 32'(w_cp0_update_ena), 32'd1);
        tail("eov", 32'hBFC00380);

        // AdEL-data with memory busy: three WAIT cycles
        req(32'h80000400, 1'b0, 10'h040, 1'b0, 32'h12345679, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        mem_busy = 1'b1;
        step(); drop(); commit_daddr = 32'h0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) mem_busy = 1'b0;
            chk($sformatf("wait%0d.busy", i), 32'(busy), 32'd1);
            chk($sformatf("wait%0d.strb", i), 32'({flush, w_cp0_update_ena, cp0_cls_exl, redirect_ena}), 32'd0);
            step();
        end
        chk("adel.upd", 32'(w_cp0_update_ena), 32'd1);
        chk("adel.code", 32'(w_cp0_exccode), 32'd4);
        chk("adel.bva", w_cp0_badvaddr, 32'h12345679);
        chk("adel.bvae", 32'(w_cp0_badvaddr_ena), 32'd1);
        tail("adel", 32'hBFC00380);

        // reset during FLUSH aborts the redirect
        req(32'h80001000, 1'b0, 10'h010, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step(); drop();
        step();
        chk("abort.inflush", 32'(flush), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort.ctl", 32'({busy, flush, redirect_ena, w_cp0_update_ena, cp0_cls_exl}), 32'd0);
        chk("abort.rpc", redirect_pc, 32'd0);
        step();
        chk("abort.noredir", 32'({busy, redirect_ena}), 32'd0);

        // Bp afterwards completes normally
        req(32'h80000500, 1'b0, 10'h020, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step(); drop();
        chk("bp.code", 32'(w_cp0_exccode), 32'd9);
        chk("bp.epc", w_cp0_epc, 32'h80000500);
        tail("bp", 32'hBFC00380);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
Exception/ERET commit sequencer between the memory-stage commit point and the cp0 register file.
- Accepts one committing instruction's exception vector, ERET flag and cp0_has_int.
- Priority-encodes to an ExcCode and drives the cp0 update strobes.
- Holds the pipeline, flushes it for a programmable number of cycles, then issues a single PC redirect to the exception vector or to EPC.

Parameters:
- EXC_BASE, 32'hBFC00200, refill vector address; the general vector is EXC_BASE+32'h180.
- FLUSH_CYCLES, 2, cycles spent in FLUSH (range 1..15).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- commit_valid  in  1  a valid instruction is at the commit point
- commit_pc  in  32  PC of the committing instruction
- commit_bd  in  1  committing instruction sits in a delay slot
- commit_exc  in  10  exception flags, bit order: [0]AdEL-fetch [1]TLBL-fetch [2]RI [3]Ov [4]Sys [5]Bp [6]AdEL-data [7]AdES [8]TLBL-data [9]TLBS
- commit_tlb_refill  in  1  the TLB exception was a refill (no matching entry)
- commit_daddr  in  32  data virtual address
- commit_eret  in  1  committing instruction is ERET
- cp0_has_int  in  1  pending enabled interrupt
- cp0_status_exl  in  1  current Status.EXL
- cp0_cause_bd  in  1  current Cause.BD
- cp0_epc  in  32  current EPC
- mem_busy  in  1  outstanding memory access not yet retired
- busy  out  1  sequencer active; pipeline holds
- flush  out  1  kill all in-flight stages
- redirect_ena  out  1  one-cycle fetch redirect
- redirect_pc  out  32  redirect target
- w_cp0_update_ena  out  1  cp0 exception-update strobe
- w_cp0_exccode  out  5  ExcCode
- w_cp0_bd  out  1  BD value to write
- w_cp0_exl  out  1  EXL value to write (always 1)
- w_cp0_epc  out  32  EPC value to write
- w_cp0_badvaddr_ena  out  1  BadVAddr write enable
- w_cp0_badvaddr  out  32  BadVAddr value
- cp0_cls_exl  out  1  clears Status.EXL (ERET)

Behaviour:
- FSM states: IDLE, WAIT, COMMIT, FLUSH, REDIRECT.
- Reset: state=IDLE and every output is 0, including all 32-bit buses. Reset mid-sequence aborts with no cp0 write and no redirect.
- Acceptance: IDLE and commit_valid and (cp0_has_int | commit_exc!=0 | commit_eret).
  - On the acceptance edge the block latches the cause, PC, target and BadVAddr.
  - Next state is WAIT if mem_busy, else COMMIT.
  - Inputs are ignored in every state except IDLE.
- Priority, highest first: INT(0); AdEL-fetch(4, BadVAddr=pc); TLBL-fetch(2, BadVAddr=pc); RI(10); Ov(12); Sys(8); Bp(9); AdEL-data(4, BadVAddr=daddr); AdES(5, BadVAddr=daddr); TLBL-data(2, BadVAddr=daddr); TLBS(3, BadVAddr=daddr).
  - Any exception outranks ERET.
  - ERET is taken only when no exception and no interrupt is present.
- Exception target:
  - EXC_BASE when the selected cause is a TLB cause with commit_tlb_refill=1 and cp0_status_exl=0.
  - EXC_BASE+0x180 otherwise.
- EPC/BD:
  - If cp0_status_exl=0: EPC = bd ? pc-4 : pc, and BD = commit_bd.
  - If cp0_status_exl=1: EPC = cp0_epc and BD = cp0_cause_bd (preserved).
  - EXL sampled at acceptance.
- ERET target: cp0_epc sampled at acceptance.
- WAIT: busy=1 and flush=0. Stays in WAIT while mem_busy, then goes to COMMIT.
- COMMIT, exactly 1 cycle:
  - Exception: w_cp0_update_ena=1, w_cp0_exl=1, and exccode/bd/epc/badvaddr valid. w_cp0_badvaddr_ena=1 only for the address causes.
  - ERET: cp0_cls_exl=1 and w_cp0_update_ena=0.
  - flush=1.
- FLUSH: flush=1 for FLUSH_CYCLES cycles (4-bit down-counter).
- REDIRECT, 1 cycle: flush=1, redirect_ena=1, redirect_pc=target. Then IDLE.
- busy=1 in every state except IDLE. All strobes are 0 outside their state; data buses are don't-care when their strobe is 0.
- Latency with mem_busy=0: accept at T, COMMIT at T+1, FLUSH at T+2..T+1+FLUSH_CYCLES, REDIRECT at T+2+FLUSH_CYCLES, IDLE at T+3+FLUSH_CYCLES. An acceptance is possible again in that IDLE cycle.

Optional Feature:
Macro CP0_EXC_CTRL_STAT_EN.
- Defined: adds outputs exc_count[31:0] and eret_count[31:0].
  - Counters are reset to 0 and wrap on overflow.
  - exc_count increments in each exception COMMIT cycle; eret_count increments in each ERET COMMIT cycle.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Sys at pc=0x80001000, bd=0, EXL=0, FLUSH_CYCLES=2 -> T+1: update_ena, exccode=8, epc=0x80001000, badvaddr_ena=0. T+2..T+3: flush=1. T+4: redirect_pc=0xBFC00380.
- TLBS with refill=1, daddr=0x00400004, EXL=0 -> exccode=3, badvaddr=0x00400004, redirect_pc=0xBFC00200. Repeat with EXL=1 -> redirect_pc=0xBFC00380, epc=cp0_epc, bd=cp0_cause_bd.
- cp0_has_int=1 with RI at bd=1, pc=0x80000104 -> exccode=0, epc=0x80000100, bd=1.
- ERET alone with cp0_epc=0x80002000 -> COMMIT: cls_exl=1, update_ena=0. REDIRECT: redirect_pc=0x80002000. ERET together with Ov -> exccode=12 and cls_exl=0.
- mem_busy=1 for 3 cycles after accepting AdEL-data -> 3 WAIT cycles with busy=1, flush=0 and no strobes, then the normal COMMIT sequence.
- rst asserted during FLUSH -> next cycle IDLE, all outputs 0, no redirect pulse. A new Bp request afterwards completes normally with exccode=9.
